control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// control_sequencer: multi-cycle fetch/decode/execute control unit driving datapath strobes.
// Rev 1.0

module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        Branch,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPc,
  output logic        MARin,
  output logic        IRin,
  output logic        Yin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        read,
  output logic        write,
  output logic [1:0]  mdr_read,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        CONin,
  output logic        InPortin,
  output logic        InPortout,
  output logic        OutPortin,
  output logic [3:0]  control,
  output logic        halted
);

  localparam logic [3:0] S_F0   = 4'd0;
  localparam logic [3:0] S_F1   = 4'd1;
  localparam logic [3:0] S_F2   = 4'd2;
  localparam logic [3:0] S_F3   = 4'd3;
  localparam logic [3:0] S_E0   = 4'd4;
  localparam logic [3:0] S_E1   = 4'd5;
  localparam logic [3:0] S_E2   = 4'd6;
  localparam logic [3:0] S_E3   = 4'd7;
  localparam logic [3:0] S_E4   = 4'd8;
  localparam logic [3:0] S_E5   = 4'd9;
  localparam logic [3:0] S_HALT = 4'd10;

  localparam logic [3:0] C_ALU3   = 4'd0;
  localparam logic [3:0] C_IMM    = 4'd1;
  localparam logic [3:0] C_NEGNOT = 4'd2;
  localparam logic [3:0] C_MULDIV = 4'd3;
  localparam logic [3:0] C_LD     = 4'd4;
  localparam logic [3:0] C_LDI    = 4'd5;
  localparam logic [3:0] C_ST     = 4'd6;
  localparam logic [3:0] C_BR     = 4'd7;
  localparam logic [3:0] C_JR     = 4'd8;
  localparam logic [3:0] C_IN     = 4'd9;
  localparam logic [3:0] C_OUT    = 4'd10;
  localparam logic [3:0] C_MFHI   = 4'd11;
  localparam logic [3:0] C_MFLO   = 4'd12;
  localparam logic [3:0] C_NOP    = 4'd13;
  localparam logic [3:0] C_HALT   = 4'd14;

  logic [3:0] state_q, state_d;
  logic [4:0] w_op;
  logic [3:0] w_cls;
  logic [3:0] w_ctl;
  logic [2:0] w_last;
  logic [3:0] w_off;
  logic [2:0] w_step;
  logic       w_unused;

  assign w_op     = IR[31:27];
  assign w_off    = state_q - S_E0;
  assign w_step   = w_off[2:0];
  assign w_unused = ^{IR[26:0], w_off[3]};

  // Instruction class, ALU op and index of the final execute step.
  always_comb begin
    w_cls  = C_NOP;
    w_ctl  = 4'b0000;
    w_last = 3'd0;
    case (w_op)
      5'b00000: begin w_cls = C_LD;  w_last = 3'd5; end
      5'b00001: begin w_cls = C_LDI; w_last = 3'd2; end
      5'b00010: begin w_cls = C_ST;  w_last = 3'd4; end
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: begin
        w_cls  = C_ALU3;
        w_ctl  = 4'(w_op - 5'd3);
        w_last = 3'd2;
      end
      5'b01011: begin w_cls = C_IMM; w_ctl = 4'b0000; w_last = 3'd2; end
      5'b01100: begin w_cls = C_IMM; w_ctl = 4'b0010; w_last = 3'd2; end
      5'b01101: begin w_cls = C_IMM; w_ctl = 4'b0011; w_last = 3'd2; end
      5'b01110, 5'b01111: begin
        w_cls = C_MULDIV; w_ctl = {3'b100, w_op[0]}; w_last = 3'd3;
      end
      5'b10000, 5'b10001: begin
        w_cls = C_NEGNOT; w_ctl = {3'b101, w_op[0]}; w_last = 3'd1;
      end
      5'b10010: begin w_cls = C_BR; w_last = 3'd3; end
      5'b10011: w_cls = C_JR;
      5'b10101: w_cls = C_IN;
      5'b10110: w_cls = C_OUT;
      5'b10111: w_cls = C_MFHI;
      5'b11000: w_cls = C_MFLO;
      5'b11010: w_cls = C_HALT;
      default:  w_cls = C_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_F0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_F0:   if (run) state_d = S_F1;
      S_F1:   state_d = S_F2;
      S_F2:   state_d = S_F3;
      S_F3: begin
        if (w_cls == C_HALT)     state_d = S_HALT;
        else if (w_cls == C_NOP) state_d = S_F0;
        else                     state_d = S_E0;
      end
      S_E0, S_E1, S_E2, S_E3, S_E4, S_E5:
        state_d = (w_step == w_last) ? S_F0 : state_q + 4'd1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_F0;
    endcase
  end

  // Everything is gated by reset so outputs clear without waiting for a clock.
  always_comb begin
    {PCout, PCin, IncPc, MARin, IRin, Yin, MDRin, MDRout, read, write} = '0;
    {Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout} = '0;
    {GRA, GRB, GRC, Rin, Rout, BAout, Cout, CONin} = '0;
    {InPortin, InPortout, OutPortin, halted} = '0;
    mdr_read = 2'b00;
    control  = 4'b0000;
    if (reset) begin
      InPortin = 1'b1;
      case (state_q)
        S_F0: if (run) begin PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zlowin = 1'b1; end
        S_F1: begin Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; end
        S_F2: begin read = 1'b1; mdr_read = 2'b01; MDRin = 1'b1; end
        S_F3: begin MDRout = 1'b1; IRin = 1'b1; end
        S_HALT: halted = 1'b1;
        S_E0, S_E1, S_E2, S_E3, S_E4, S_E5: begin
          case (w_cls)
            C_ALU3, C_IMM: case (w_step)
              3'd0: begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              3'd1: begin
                Zlowin = 1'b1; control = w_ctl;
                if (w_cls == C_IMM) Cout = 1'b1;
                else begin GRC = 1'b1; Rout = 1'b1; end
              end
              3'd2: begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
            C_NEGNOT: case (w_step)
              3'd0: begin GRB = 1'b1; Rout = 1'b1; control = w_ctl; Zlowin = 1'b1; end
              3'd1: begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
            C_MULDIV: case (w_step)
              3'd0: begin GRA = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              3'd1: begin GRB = 1'b1; Rout = 1'b1; control = w_ctl; Zlowin = 1'b1; Zhighin = 1'b1; end
              3'd2: begin Zlowout = 1'b1; LOin = 1'b1; end
              3'd3: begin Zhighout = 1'b1; HIin = 1'b1; end
              default: ;
            endcase
            C_LD, C_LDI, C_ST: case (w_step)
              3'd0: begin GRB = 1'b1; BAout = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              3'd1: begin Cout = 1'b1; Zlowin = 1'b1; end
              3'd2: begin
                Zlowout = 1'b1;
                if (w_cls == C_LDI) begin GRA = 1'b1; Rin = 1'b1; end
                else MARin = 1'b1;
              end
              3'd3: begin
                if (w_cls == C_ST) begin GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                else read = 1'b1;
              end
              3'd4: begin
                if (w_cls == C_ST) write = 1'b1;
                else begin read = 1'b1; mdr_read = 2'b01; MDRin = 1'b1; end
              end
              3'd5: begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
            C_BR: case (w_step)
              3'd0: begin GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; end
              3'd1: begin PCout = 1'b1; Yin = 1'b1; end
              3'd2: begin Cout = 1'b1; Zlowin = 1'b1; end
              3'd3: if (Branch) begin Zlowout = 1'b1; PCin = 1'b1; end
              default: ;
            endcase
            C_JR:   begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            C_IN:   begin InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
            C_OUT:  begin GRA = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
            C_MFHI: begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
            C_MFLO: begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// tb_control_sequencer: directed stimulus with a queued expected-output scoreboard.
// Rev 1.0

module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, Branch;
  logic [31:0] IR;
  logic PCout, PCin, IncPc, MARin, IRin, Yin, MDRin, MDRout, read, write;
  logic [1:0] mdr_read;
  logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
  logic GRA, GRB, GRC, Rin, Rout, BAout, Cout, CONin;
  logic InPortin, InPortout, OutPortin, halted;
  logic [3:0] control;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .IR(IR), .Branch(Branch),
    .PCout(PCout), .PCin(PCin), .IncPc(IncPc), .MARin(MARin), .IRin(IRin), .Yin(Yin),
    .MDRin(MDRin), .MDRout(MDRout), .read(read), .write(write), .mdr_read(mdr_read),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .CONin(CONin), .InPortin(InPortin), .InPortout(InPortout),
    .OutPortin(OutPortin), .control(control), .halted(halted)
  );

  logic [35:0] w_obs;
  assign w_obs = {halted, control, OutPortin, InPortout, InPortin, CONin, Cout, BAout,
                  Rout, Rin, GRC, GRB, GRA, LOout, HIout, LOin, HIin, Zhighout, Zlowout,
                  Zhighin, Zlowin, mdr_read, write, read, MDRout, MDRin, Yin, IRin, MARin,
                  IncPc, PCin, PCout};

  localparam logic [35:0] M_PCO  = 36'd1 << 0;
  localparam logic [35:0] M_PCI  = 36'd1 << 1;
  localparam logic [35:0] M_INC  = 36'd1 << 2;
  localparam logic [35:0] M_MAR  = 36'd1 << 3;
  localparam logic [35:0] M_IRI  = 36'd1 << 4;
  localparam logic [35:0] M_YIN  = 36'd1 << 5;
  localparam logic [35:0] M_MDRI = 36'd1 << 6;
  localparam logic [35:0] M_MDRO = 36'd1 << 7;
  localparam logic [35:0] M_RD   = 36'd1 << 8;
  localparam logic [35:0] M_WR   = 36'd1 << 9;
  localparam logic [35:0] M_MEM  = 36'd1 << 10;
  localparam logic [35:0] M_ZLI  = 36'd1 << 12;
  localparam logic [35:0] M_ZHI  = 36'd1 << 13;
  localparam logic [35:0] M_ZLO  = 36'd1 << 14;
  localparam logic [35:0] M_ZHO  = 36'd1 << 15;
  localparam logic [35:0] M_HII  = 36'd1 << 16;
  localparam logic [35:0] M_LOI  = 36'd1 << 17;
  localparam logic [35:0] M_HIO  = 36'd1 << 18;
  localparam logic [35:0] M_LOO  = 36'd1 << 19;
  localparam logic [35:0] M_GA   = 36'd1 << 20;
  localparam logic [35:0] M_GB   = 36'd1 << 21;
  localparam logic [35:0] M_GC   = 36'd1 << 22;
  localparam logic [35:0] M_RIN  = 36'd1 << 23;
  localparam logic [35:0] M_ROUT = 36'd1 << 24;
  localparam logic [35:0] M_BA   = 36'd1 << 25;
  localparam logic [35:0] M_CO   = 36'd1 << 26;
  localparam logic [35:0] M_CON  = 36'd1 << 27;
  localparam logic [35:0] M_INP  = 36'd1 << 28;
  localparam logic [35:0] M_INPO = 36'd1 << 29;
  localparam logic [35:0] M_OUTP = 36'd1 << 30;
  localparam logic [35:0] M_HLT  = 36'd1 << 35;

  localparam logic [35:0] X_F0 = M_PCO | M_MAR | M_INC | M_ZLI;
  localparam logic [35:0] X_F1 = M_ZLO | M_PCI | M_RD;
  localparam logic [35:0] X_F2 = M_RD | M_MEM | M_MDRI;
  localparam logic [35:0] X_F3 = M_MDRO | M_IRI;

  typedef struct {
    logic [35:0] v;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [35:0] ctl(input logic [3:0] c);
    return {1'b0, c, 31'h0};
  endfunction

  function automatic logic [31:0] op(input logic [4:0] o);
    return {o, 27'h0};
  endfunction

  // Strobes expected for the current cycle; InPortin follows reset.
  task automatic push(input logic [35:0] v, input string nm);
    exp_t e;
    e.v  = reset ? (v | M_INP) : v;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [35:0] v, input string nm);
    @(posedge clk);
    #1;
    push(v, nm);
  endtask

  task automatic fetch_rest(input logic [31:0] ir);
    IR = ir;
    cyc(X_F1, "f1");
    cyc(X_F2, "f2");
    cyc(X_F3, "f3");
  endtask

  task automatic fetch(input logic [31:0] ir);
    cyc(X_F0, "f0");
    fetch_rest(ir);
  endtask

  task automatic ld_head(input string tag);
    cyc(M_GB | M_BA | M_ROUT | M_YIN, {tag, "_e0"});
    cyc(M_CO | M_ZLI, {tag, "_e1"});
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (w_obs !== e.v) begin
        bad++;
        $display("FAIL %s: got %h want %h at %0t", e.nm, w_obs, e.v, $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; run = 1'b1; Branch = 1'b0; IR = 32'h0;
    repeat (3) cyc(36'h0, "reset_state");

    // Release: F0 visible in the first cycle, IRin in the fourth.
    @(posedge clk); #1; reset = 1'b1; push(X_F0, "rel_f0");
    fetch_rest(32'h18918000);
    cyc(M_GB | M_ROUT | M_YIN, "add_e0");
    cyc(M_GC | M_ROUT | M_ZLI | ctl(4'b0000), "add_e1");
    cyc(M_ZLO | M_GA | M_RIN, "add_e2");

    fetch(op(5'b01011));
    cyc(M_GB | M_ROUT | M_YIN, "addi_e0");
    cyc(M_CO | M_ZLI | ctl(4'b0000), "addi_e1");
    cyc(M_ZLO | M_GA | M_RIN, "addi_e2");

    fetch(op(5'b00100));
    cyc(M_GB | M_ROUT | M_YIN, "sub_e0");
    cyc(M_GC | M_ROUT | M_ZLI | ctl(4'b0001), "sub_e1");
    cyc(M_ZLO | M_GA | M_RIN, "sub_e2");

    fetch(op(5'b01010));
    cyc(M_GB | M_ROUT | M_YIN, "rol_e0");
    cyc(M_GC | M_ROUT | M_ZLI | ctl(4'b0111), "rol_e1");
    cyc(M_ZLO | M_GA | M_RIN, "rol_e2");

    fetch(op(5'b01101));
    cyc(M_GB | M_ROUT | M_YIN, "ori_e0");
    cyc(M_CO | M_ZLI | ctl(4'b0011), "ori_e1");
    cyc(M_ZLO | M_GA | M_RIN, "ori_e2");

    fetch(op(5'b01110));
    cyc(M_GA | M_ROUT | M_YIN, "mul_e0");
    cyc(M_GB | M_ROUT | M_ZLI | M_ZHI | ctl(4'b1000), "mul_e1");
    cyc(M_ZLO | M_LOI, "mul_e2");
    cyc(M_ZHO | M_HII, "mul_e3");

    fetch(op(5'b01111));
    cyc(M_GA | M_ROUT | M_YIN, "div_e0");
    cyc(M_GB | M_ROUT | M_ZLI | M_ZHI | ctl(4'b1001), "div_e1");
    cyc(M_ZLO | M_LOI, "div_e2");
    cyc(M_ZHO | M_HII, "div_e3");

    fetch(op(5'b10001));
    cyc(M_GB | M_ROUT | M_ZLI | ctl(4'b1011), "not_e0");
    cyc(M_ZLO | M_GA | M_RIN, "not_e1");

    fetch(op(5'b00000));
    ld_head("ld");
    cyc(M_ZLO | M_MAR, "ld_e2");
    cyc(M_RD, "ld_e3");
    cyc(M_RD | M_MEM | M_MDRI, "ld_e4");
    cyc(M_MDRO | M_GA | M_RIN, "ld_e5");

    fetch(op(5'b00010));
    ld_head("st");
    cyc(M_ZLO | M_MAR, "st_e2");
    cyc(M_GA | M_ROUT | M_MDRI, "st_e3");
    cyc(M_WR, "st_e4");

    cyc(X_F0, "f0"); Branch = 1'b0; fetch_rest(op(5'b10010));
    cyc(M_GA | M_ROUT | M_CON, "br0_e0");
    cyc(M_PCO | M_YIN, "br0_e1");
    cyc(M_CO | M_ZLI, "br0_e2");
    cyc(36'h0, "br0_br3");

    cyc(X_F0, "f0"); Branch = 1'b1; fetch_rest(op(5'b10010));
    cyc(M_GA | M_ROUT | M_CON, "br1_e0");
    cyc(M_PCO | M_YIN, "br1_e1");
    cyc(M_CO | M_ZLI, "br1_e2");
    cyc(M_ZLO | M_PCI, "br1_br3");

    fetch(op(5'b10011)); cyc(M_GA | M_ROUT | M_PCI, "jr_e0");
    fetch(op(5'b10101)); cyc(M_INPO | M_GA | M_RIN, "in_e0");
    fetch(op(5'b10110)); cyc(M_GA | M_ROUT | M_OUTP, "out_e0");
    fetch(op(5'b10111)); cyc(M_HIO | M_GA | M_RIN, "mfhi_e0");
    fetch(op(5'b11000)); cyc(M_LOO | M_GA | M_RIN, "mflo_e0");
    fetch(op(5'b11001));
    fetch(op(5'b11111));
    fetch(op(5'b10100));

    // run dropped mid-instruction: ldi still completes, then F0 holds idle.
    fetch(op(5'b00001));
    cyc(M_GB | M_BA | M_ROUT | M_YIN, "ldi_e0");
    run = 1'b0;
    cyc(M_CO | M_ZLI, "ldi_e1");
    cyc(M_ZLO | M_GA | M_RIN, "ldi_e2");
    repeat (3) cyc(36'h0, "run0_hold");
    @(posedge clk); #1; run = 1'b1; push(X_F0, "run1_f0");

    // Reset pulse in ld E3 aborts; after release the next edge leaves F0.
    fetch_rest(op(5'b00000));
    ld_head("ldr");
    cyc(M_ZLO | M_MAR, "ldr_e2");
    @(posedge clk); #1; reset = 1'b0; push(36'h0, "rst_mid_ld");
    @(negedge clk); #2; reset = 1'b1;

    fetch_rest(op(5'b11010));
    repeat (100) cyc(M_HLT, "halt_hold");
    @(posedge clk); #3; reset = 1'b0; push(36'h0, "halt_async_rst");
    repeat (2) cyc(36'h0, "rst_hold");
    @(posedge clk); #1; reset = 1'b1; push(X_F0, "rel2_f0");
    fetch_rest(op(5'b11001));
    cyc(X_F0, "post_nop_f0");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
